// File: rtl/tt_sweep_pkg.sv
// Shared types and defaults for the truth-table sweep controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tt_sweep_pkg;

  // Sweep sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Default number of function inputs and the matching vector count
  localparam int N_IN_DEF = 4;
  localparam int NVEC     = 1 << N_IN_DEF;

endpackage

// File: rtl/tt_settle_cnt.sv
// Settle-time down-counter: load, decrement toward zero, zero flag.
// Latency: zero flag reflects the registered count (1 cycle after load).
// Backpressure: none; dec is ignored once the count reaches zero.
module tt_settle_cnt #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load has priority, decrement stops at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Exhaustive truth-table sweep of an external combinational block, with compare vs expected mask.
// Latency: SETTLE+2 cycles per vector; done 2^N_IN*(SETTLE+2)+1 cycles counting the start cycle.
// Backpressure: none; start is ignored while busy, abort cancels from any state.
module tt_sweep_ctrl
  import tt_sweep_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [(1<<N_IN)-1:0] exp_mask,
  output logic [N_IN-1:0]      dut_in,
  input  logic                 dut_out,
  output logic                 busy,
  output logic                 done,
  output logic [(1<<N_IN)-1:0] tt_out,
  output logic [N_IN:0]        err_cnt,
  output logic                 pass
);

  localparam int NV = 1 << N_IN;
  // A zero settle time still needs a 1-bit counter so the port has width
  localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  state_t          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [NV-1:0]   mask_q, mask_d;
  logic [NV-1:0]   tt_q, tt_d;
  logic [N_IN:0]   err_q, err_d;
  logic            pass_q, pass_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [N_IN-1:0] din_q, din_d;
  logic            cnt_load, cnt_dec, cnt_zero;

  tt_settle_cnt #(.W(CW)) u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (CW'(SETTLE)),
    .zero     (cnt_zero)
  );

  // Sequencer next-state and result accumulation; abort overrides everything
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mask_d   = mask_q;
    tt_d     = tt_q;
    err_d    = err_q;
    pass_d   = pass_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    if (abort) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mask_d   = exp_mask;
            tt_d     = '0;
            err_d    = '0;
            pass_d   = 1'b0;
            idx_d    = '0;
            cnt_load = 1'b1;
            busy_d   = 1'b1;
            state_d  = APPLY;
          end
        end
        APPLY: begin
          if (cnt_zero) begin
            state_d = SAMPLE;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        SAMPLE: begin
          tt_d[idx_q] = dut_out;
          if (dut_out != mask_q[idx_q]) begin
            err_d = err_q + (N_IN+1)'(1);
          end
          if (idx_q == '1) begin
            // Pass must include the final sample, so it uses err_d not err_q
            state_d = DONE;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end else begin
            idx_d    = idx_q + N_IN'(1);
            cnt_load = 1'b1;
            state_d  = APPLY;
          end
        end
        DONE: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
    // Vector is presented only while a vector is being applied or sampled
    din_d = ((state_d == APPLY) || (state_d == SAMPLE)) ? idx_d : '0;
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mask_q  <= '0;
      tt_q    <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      tt_q    <= tt_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      din_q   <= din_d;
    end
  end

  assign dut_in  = din_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign tt_out  = tt_q;
  assign err_cnt = err_q;
  assign pass    = pass_q;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Self-checking bench for tt_sweep_ctrl: SETTLE=1 and SETTLE=0 instances driven by a modelled block.
// Latency: expected timing derived from vector count and settle time.
// Backpressure: n/a.
module tb_tt_sweep_ctrl;
  import tt_sweep_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] exp_mask = '0;
  logic [15:0] blk = '0;
  bit          use_b = 1'b0;

  logic [3:0]  dut_in_a, dut_in_b;
  logic        busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [15:0] tt_a, tt_b;
  logic [4:0]  err_a, err_b;
  logic        dut_out_a, dut_out_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Modelled function block: blk is its truth table, indexed by {x,y,w,z}
  assign dut_out_a = blk[dut_in_a];
  assign dut_out_b = blk[dut_in_b];

  logic [3:0]  o_din;
  logic        o_busy, o_done, o_pass;
  logic [15:0] o_tt;
  logic [4:0]  o_err;
  assign o_din  = use_b ? dut_in_b : dut_in_a;
  assign o_busy = use_b ? busy_b   : busy_a;
  assign o_done = use_b ? done_b   : done_a;
  assign o_pass = use_b ? pass_b   : pass_a;
  assign o_tt   = use_b ? tt_b     : tt_a;
  assign o_err  = use_b ? err_b    : err_a;

  tt_sweep_ctrl #(.N_IN(4), .SETTLE(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort), .exp_mask(exp_mask),
    .dut_in(dut_in_a), .dut_out(dut_out_a), .busy(busy_a), .done(done_a),
    .tt_out(tt_a), .err_cnt(err_a), .pass(pass_a)
  );

  tt_sweep_ctrl #(.N_IN(4), .SETTLE(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort), .exp_mask(exp_mask),
    .dut_in(dut_in_b), .dut_out(dut_out_b), .busy(busy_b), .done(done_b),
    .tt_out(tt_b), .err_cnt(err_b), .pass(pass_b)
  );

  always #5 clk = ~clk;

  function automatic int popcnt(input logic [15:0] v);
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic pulse_start();
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_tests++;
      if ({dut_in_a, busy_a, done_a, tt_a, err_a, pass_a, dut_in_b, busy_b, done_b, tt_b, err_b, pass_b} !== '0) begin
        n_fail++;
        $display("FAIL reset_idle cyc %0d: a=%h/%b/%b/%h/%h/%b b=%h/%b/%b/%h/%h/%b want all 0", c,
                 dut_in_a, busy_a, done_a, tt_a, err_a, pass_a, dut_in_b, busy_b, done_b, tt_b, err_b, pass_b);
      end
    end
  endtask

  // Full sweep; cycle 1 is the cycle right after the edge that accepts start
  task automatic do_sweep(input logic [15:0] bv, input logic [15:0] mv, input bit disturb, input string nm);
    int per      = use_b ? 2 : 3;
    int exp_done = NVEC * per + 1;
    int exp_err  = popcnt(bv ^ mv);
    int done_at  = -1;
    int ndone    = 0;
    int bad      = 0;
    int first_bad = -1;
    int busy_bad = 0;
    logic [3:0]  exp_din;
    logic [15:0] cap_tt = '0;
    logic [4:0]  cap_err = '0;
    logic        cap_pass = 1'b0;
    blk      = bv;
    exp_mask = mv;
    pulse_start();
    for (int c = 1; c <= exp_done + 5; c++) begin
      exp_din = (c - 1 < NVEC * per) ? 4'((c - 1) / per) : 4'd0;
      if (o_din !== exp_din) begin
        bad++;
        if (first_bad < 0) first_bad = c;
      end
      if (o_busy !== ((c <= exp_done) ? 1'b1 : 1'b0)) busy_bad++;
      if (o_done === 1'b1) begin
        ndone++;
        if (done_at < 0) begin
          done_at  = c;
          cap_tt   = o_tt;
          cap_err  = o_err;
          cap_pass = o_pass;
        end
      end
      if (disturb && c == 10) start_a = 1'b1;
      if (disturb && c == 11) start_a = 1'b0;
      if (disturb && c == 20) exp_mask = '0;
      @(negedge clk);
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s dut_in_seq: %0d wrong cycles, first at %0d, want 0 wrong", nm, bad, first_bad);
    end
    n_tests++;
    if (busy_bad != 0) begin
      n_fail++;
      $display("FAIL %s busy_window: %0d wrong cycles, want 0", nm, busy_bad);
    end
    n_tests++;
    if (done_at != exp_done || ndone != 1) begin
      n_fail++;
      $display("FAIL %s done_timing: at %0d count %0d, want at %0d count 1", nm, done_at, ndone, exp_done);
    end
    n_tests++;
    if (cap_tt !== bv) begin
      n_fail++;
      $display("FAIL %s tt_out: got %h want %h", nm, cap_tt, bv);
    end
    n_tests++;
    if (int'(cap_err) != exp_err) begin
      n_fail++;
      $display("FAIL %s err_cnt: got %0d want %0d", nm, cap_err, exp_err);
    end
    n_tests++;
    if (cap_pass !== (exp_err == 0)) begin
      n_fail++;
      $display("FAIL %s pass: got %b want %b", nm, cap_pass, (exp_err == 0));
    end
    n_tests++;
    if (o_pass !== (exp_err == 0)) begin
      n_fail++;
      $display("FAIL %s pass_hold: got %b want %b", nm, o_pass, (exp_err == 0));
    end
  endtask

  task automatic test_sweeps();
    use_b = 1'b0;
    do_sweep(16'h7970, 16'h7970, 1'b0, "match");
    do_sweep(16'h7970, 16'h7971, 1'b0, "one_off");
    do_sweep(16'h0000, 16'hFFFF, 1'b0, "all_wrong");
    do_sweep(16'h7970, 16'h7970, 1'b1, "disturb");
    use_b = 1'b1;
    do_sweep(16'h7970, 16'h7971, 1'b0, "settle0");
    use_b = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] bv, mv;
    for (int k = 0; k < 6; k++) begin
      bv = 16'($urandom);
      mv = ($urandom_range(0, 1) == 0) ? bv : 16'($urandom);
      use_b = ($urandom_range(0, 1) == 1);
      do_sweep(bv, mv, 1'b0, "random");
    end
    use_b = 1'b0;
  endtask

  task automatic test_start_abort_same();
    int bad = 0;
    use_b = 1'b0;
    start_a = 1'b1;
    abort   = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    abort   = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (busy_a !== 1'b0 || dut_in_a !== 4'd0) bad++;
      @(negedge clk);
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL start_abort_same: %0d busy/dut_in cycles wrong, want 0", bad);
    end
  endtask

  task automatic test_abort();
    logic [15:0] bv = 16'hA5C3;
    logic [15:0] mv = 16'h5AC3;
    int waited = 0;
    int dones = 0;
    use_b = 1'b0;
    blk = bv;
    exp_mask = mv;
    pulse_start();
    while (dut_in_a !== 4'd5 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    n_tests++;
    if (waited >= 100) begin
      n_fail++;
      $display("FAIL abort_reach_idx5: dut_in %0d, want 5 within 100 cycles", dut_in_a);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_tests++;
    if (busy_a !== 1'b0 || dut_in_a !== 4'd0 || done_a !== 1'b0 || pass_a !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_outputs: busy %b dut_in %0d done %b pass %b, want 0 0 0 0", busy_a, dut_in_a, done_a, pass_a);
    end
    n_tests++;
    if (tt_a !== (bv & 16'h001F) || int'(err_a) != popcnt((bv ^ mv) & 16'h001F)) begin
      n_fail++;
      $display("FAIL abort_partial: tt %h err %0d, want tt %h err %0d", tt_a, err_a, bv & 16'h001F,
               popcnt((bv ^ mv) & 16'h001F));
    end
    for (int c = 0; c < 60; c++) begin
      if (done_a === 1'b1 || busy_a === 1'b1) dones++;
      @(negedge clk);
    end
    n_tests++;
    if (dones != 0) begin
      n_fail++;
      $display("FAIL abort_no_done: %0d cycles with done/busy, want 0", dones);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int waited = 0;
    use_b = 1'b0;
    blk = 16'h7970;
    exp_mask = 16'h7970;
    pulse_start();
    while (dut_in_a !== 4'd9 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    n_tests++;
    if (waited >= 100) begin
      n_fail++;
      $display("FAIL rst_reach_idx9: dut_in %0d, want 9 within 100 cycles", dut_in_a);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({dut_in_a, busy_a, done_a, tt_a, err_a, pass_a} !== '0) begin
      n_fail++;
      $display("FAIL rst_async_clear: dut_in %0d busy %b done %b tt %h err %0d pass %b, want all 0",
               dut_in_a, busy_a, done_a, tt_a, err_a, pass_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_sweep(16'h7970, 16'h7970, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_sweeps();
    test_random();
    test_start_abort_same();
    test_abort();
    test_reset_mid_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
